// File: rtl/spc_smp_pkg.sv
// Shared constants for the SMP I/O register block: bus addresses, default
// prescaler ratios and the address-decode helper.
package spc_smp_pkg;

    localparam logic [15:0] ADDR_CTRL  = 16'h00F1;
    localparam logic [15:0] ADDR_T0DIV = 16'h00FA;
    localparam logic [15:0] ADDR_T1DIV = 16'h00FB;
    localparam logic [15:0] ADDR_T2DIV = 16'h00FC;
    localparam logic [15:0] ADDR_T0OUT = 16'h00FD;
    localparam logic [15:0] ADDR_T1OUT = 16'h00FE;
    localparam logic [15:0] ADDR_T2OUT = 16'h00FF;

    localparam int unsigned T01_PRESCALE_DEF = 32'd128;
    localparam int unsigned T2_PRESCALE_DEF  = 32'd16;

    // True for every address this block owns: $F1 and $FA-$FF.
    function automatic logic addr_hit(input logic [15:0] addr);
        return (addr == ADDR_CTRL) || ((addr >= ADDR_T0DIV) && (addr <= ADDR_T2OUT));
    endfunction

endpackage

// File: rtl/spc_smp_timers_if.sv
// CPU-side bus seen by the SMP register block; the core drives it,
// the register block answers with SEL and combinational read data.
interface spc_smp_timers_if;
    logic        EN;
    logic [15:0] ADDR;
    logic [7:0]  DI;
    logic        WE_N;
    logic [7:0]  DO;
    logic        SEL;

    modport master (output EN, output ADDR, output DI, output WE_N, input DO, input SEL);
    modport slave  (input EN, input ADDR, input DI, input WE_N, output DO, output SEL);
endinterface

// File: rtl/spc_smp_timer.sv
// One stage-2 timer: 8-bit up-counter compared against DIV, feeding a
// 4-bit output counter that clears on read without losing a coincident count.
module spc_smp_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       en_i,
    input  logic       en_set_i,
    input  logic       rd_i,
    input  logic [7:0] div_i,
    output logic [3:0] out_o
);

    logic [7:0] cnt_q, cnt_d, nxt_s;
    logic [3:0] out_q, out_d;
    logic       fire_s;

    // Next-state: enable rising edge wins over a tick; a read keeps a coincident increment.
    always_comb begin
        nxt_s  = cnt_q + 8'd1;
        fire_s = tick_i & en_i & (nxt_s == div_i);
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (en_set_i) begin
            cnt_d = 8'd0;
            out_d = 4'd0;
        end else begin
            if (tick_i & en_i) begin
                cnt_d = fire_s ? 8'd0 : nxt_s;
            end else begin
                cnt_d = cnt_q;
            end
            if (rd_i) begin
                out_d = fire_s ? 4'd1 : 4'd0;
            end else if (fire_s) begin
                out_d = out_q + 4'd1;
            end else begin
                out_d = out_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            out_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/spc_smp_timers.sv
// SMP I/O register block: control register, three timers with shared
// prescalers, combinational read-back and the IPL/port-clear controls.
module spc_smp_timers
    import spc_smp_pkg::*;
#(
    parameter int unsigned T01_PRESCALE = T01_PRESCALE_DEF,
    parameter int unsigned T2_PRESCALE  = T2_PRESCALE_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    spc_smp_timers_if.slave   bus,
    output logic              IPL_EN,
    output logic              CLR_P01,
    output logic              CLR_P23
);

    localparam int W01 = $clog2(T01_PRESCALE);
    localparam int W2  = $clog2(T2_PRESCALE);

    logic [W01-1:0]  pre01_q, pre01_d;
    logic [W2-1:0]   pre2_q, pre2_d;
    logic            tick01_s, tick2_s;
    logic [2:0]      tick_s;

    logic [2:0]      ctrl_q, ctrl_d;
    logic            ipl_q, ipl_d;
    logic            clr01_q, clr01_d;
    logic            clr23_q, clr23_d;
    logic [2:0][7:0] div_q, div_d;

    logic            sel_s, wr_s, rd_s, ctrl_wr_s;
    logic [2:0]      en_set_s;
    logic [3:0]      out_s [3];
    logic            unused_ok_s;

    assign sel_s     = addr_hit(bus.ADDR);
    assign wr_s      = bus.EN & ~bus.WE_N & sel_s;
    assign rd_s      = bus.EN & bus.WE_N & sel_s;
    assign ctrl_wr_s = wr_s & (bus.ADDR == ADDR_CTRL);
    assign en_set_s  = ctrl_wr_s ? (bus.DI[2:0] & ~ctrl_q) : 3'b000;
    assign unused_ok_s = bus.DI[6] ^ bus.DI[3];

    assign tick01_s = CE & (pre01_q == W01'(T01_PRESCALE - 32'd1));
    assign tick2_s  = CE & (pre2_q == W2'(T2_PRESCALE - 32'd1));
    assign tick_s   = {tick2_s, tick01_s, tick01_s};

    // Free-running prescalers; only RST realigns their phase.
    always_comb begin
        pre01_d = pre01_q;
        pre2_d  = pre2_q;
        if (CE) begin
            pre01_d = tick01_s ? '0 : pre01_q + W01'(1);
            pre2_d  = tick2_s  ? '0 : pre2_q + W2'(1);
        end else begin
            pre01_d = pre01_q;
            pre2_d  = pre2_q;
        end
    end

    // Control and divider register writes; port-clear strobes last one cycle.
    always_comb begin
        ctrl_d  = ctrl_q;
        ipl_d   = ipl_q;
        clr01_d = 1'b0;
        clr23_d = 1'b0;
        div_d   = div_q;
        if (ctrl_wr_s) begin
            ctrl_d  = bus.DI[2:0];
            ipl_d   = bus.DI[7];
            clr01_d = bus.DI[4];
            clr23_d = bus.DI[5];
        end else begin
            ctrl_d  = ctrl_q;
            ipl_d   = ipl_q;
        end
        for (int n = 0; n < 3; n++) begin
            if (wr_s && (bus.ADDR == (ADDR_T0DIV + 16'(n)))) begin
                div_d[n] = bus.DI;
            end else begin
                div_d[n] = div_q[n];
            end
        end
    end

    // Block state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre01_q <= '0;
            pre2_q  <= '0;
            ctrl_q  <= 3'b000;
            ipl_q   <= 1'b1;
            clr01_q <= 1'b0;
            clr23_q <= 1'b0;
            div_q   <= '0;
        end else begin
            pre01_q <= pre01_d;
            pre2_q  <= pre2_d;
            ctrl_q  <= ctrl_d;
            ipl_q   <= ipl_d;
            clr01_q <= clr01_d;
            clr23_q <= clr23_d;
            div_q   <= div_d;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_tmr
        spc_smp_timer u_timer (
            .clk_i    (CLK),
            .rst_i    (RST),
            .tick_i   (tick_s[g]),
            .en_i     (ctrl_q[g]),
            .en_set_i (en_set_s[g]),
            .rd_i     (rd_s & (bus.ADDR == (ADDR_T0OUT + 16'(g)))),
            .div_i    (div_q[g]),
            .out_o    (out_s[g])
        );
    end

    // Read-back mux: only the output counters are readable.
    always_comb begin
        case (bus.ADDR)
            ADDR_T0OUT: bus.DO = {4'h0, out_s[0]};
            ADDR_T1OUT: bus.DO = {4'h0, out_s[1]};
            ADDR_T2OUT: bus.DO = {4'h0, out_s[2]};
            default:    bus.DO = 8'h00;
        endcase
    end

    assign bus.SEL = sel_s;
    assign IPL_EN  = ipl_q;
    assign CLR_P01 = clr01_q;
    assign CLR_P23 = clr23_q;

endmodule
